// File: rtl/shift_register_univ.sv
// Universal shift register: hold, shift right/left, parallel load, word-shifted flag.
// Optional SHIFT_ROTATE_EN adds a rot input turning both shifts into rotations.
module shift_register_univ #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}},
    localparam int              CNT_W   = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic [WIDTH-1:0] d,
`ifdef SHIFT_ROTATE_EN
    input  logic             rot,
`endif
    output logic [WIDTH-1:0] q,
    output logic             sout_r,
    output logic             sout_l,
    output logic [CNT_W-1:0] cnt,
    output logic             done
);

    typedef enum logic [1:0] {
        M_HOLD  = 2'b00,
        M_RIGHT = 2'b01,
        M_LEFT  = 2'b10,
        M_LOAD  = 2'b11
    } mode_e;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

    logic [WIDTH-1:0] q_q, q_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             fill_r, fill_l;
    logic             shift;

`ifdef SHIFT_ROTATE_EN
    assign fill_r = rot ? q_q[0] : sin_r;
    assign fill_l = rot ? q_q[WIDTH-1] : sin_l;
`else
    assign fill_r = sin_r;
    assign fill_l = sin_l;
`endif

    always_comb begin
        q_d    = q_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        shift  = 1'b0;
        if (en) begin
            unique case (mode_e'(mode))
                M_HOLD: ;
                M_RIGHT: begin
                    q_d   = {fill_r, q_q[WIDTH-1:1]};
                    shift = 1'b1;
                end
                M_LEFT: begin
                    q_d   = {q_q[WIDTH-2:0], fill_l};
                    shift = 1'b1;
                end
                M_LOAD: begin
                    q_d   = d;
                    cnt_d = '0;
                end
                default: ;
            endcase
        end
        // Saturate at WIDTH so done fires once per load.
        if (shift && (cnt_q < CNT_MAX)) begin
            cnt_d  = cnt_q + 1'b1;
            done_d = (cnt_q == CNT_MAX - 1'b1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q    <= RST_VAL;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign q      = q_q;
    assign cnt    = cnt_q;
    assign done   = done_q;
    assign sout_r = q_q[0];
    assign sout_l = q_q[WIDTH-1];

endmodule

// File: tb/tb_shift_register_univ.sv
// Scoreboard bench for shift_register_univ (WIDTH=8).
// Rotation scenario runs only when SHIFT_ROTATE_EN is defined.
module tb_shift_register_univ;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic       sin_r;
    logic       sin_l;
    logic [7:0] d;
    logic [7:0] q;
    logic       sout_r;
    logic       sout_l;
    logic [3:0] cnt;
    logic       done;
`ifdef SHIFT_ROTATE_EN
    logic       rot;
`endif

    typedef struct packed {
        logic [7:0] q;
        logic [3:0] cnt;
        logic       done;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    logic [7:0] m_q;
    logic [3:0] m_cnt;
    int         errors = 0;
    int         checks = 0;

    shift_register_univ #(.WIDTH(8), .RST_VAL(8'h00)) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .mode   (mode),
        .sin_r  (sin_r),
        .sin_l  (sin_l),
        .d      (d),
`ifdef SHIFT_ROTATE_EN
        .rot    (rot),
`endif
        .q      (q),
        .sout_r (sout_r),
        .sout_l (sout_l),
        .cnt    (cnt),
        .done   (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // Drive one cycle, advance the reference model, queue the expected outcome.
    task automatic drive(input logic e_i, input logic [1:0] m_i,
                         input logic sr, input logic sl,
                         input logic [7:0] dd, input logic rt);
        logic dn;
        logic fr, fl;
        exp_t x;
        en = e_i; mode = m_i; sin_r = sr; sin_l = sl; d = dd;
`ifdef SHIFT_ROTATE_EN
        rot = rt;
`endif
        fr = rt ? m_q[0] : sr;
        fl = rt ? m_q[7] : sl;
        dn = 1'b0;
        if (e_i) begin
            if (m_i == 2'b11) begin
                m_q = dd;
                m_cnt = 4'd0;
            end else if (m_i != 2'b00) begin
                m_q = (m_i == 2'b01) ? {fr, m_q[7:1]} : {m_q[6:0], fl};
                if (m_cnt < 4'd8) begin
                    dn = (m_cnt == 4'd7);
                    m_cnt = m_cnt + 4'd1;
                end
            end
        end
        x.q = m_q; x.cnt = m_cnt; x.done = dn;
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b0; mode = 2'b00;
        sin_r = 1'b0; sin_l = 1'b0; d = 8'h00;
`ifdef SHIFT_ROTATE_EN
        rot = 1'b0;
`endif
        m_q = 8'h00; m_cnt = 4'd0;
        #12;
        checks++;
        if (q !== 8'h00 || cnt !== 4'd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_init: q=%h cnt=%0d done=%b want 00/0/0", q, cnt, done);
        end
        rst = 1'b1;
        #4;
        drive(1, 2'b11, 0, 0, 8'hA5, 0);
        e = sb.pop_front();
        checks++;
        if (q !== 8'hA5 || q !== e.q || cnt !== e.cnt || done !== e.done) begin
            errors++;
            $display("FAIL reset_load: q=%h cnt=%0d done=%b want %h/%0d/%b", q, cnt, done, e.q, e.cnt, e.done);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (q !== 8'h00 || cnt !== 4'd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: q=%h cnt=%0d done=%b want 00/0/0", q, cnt, done);
        end
        m_q = 8'h00; m_cnt = 4'd0;
        @(posedge clk);
        #3 rst = 1'b1;
        drive(1, 2'b11, 0, 0, 8'hA5, 0);
        for (int i = 0; i < 7; i++) drive(1, 2'b01, 0, 0, 8'h00, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
        end
        #2 rst = 1'b0;
        m_q = 8'h00; m_cnt = 4'd0;
        @(posedge clk);
        #3 rst = 1'b1;
        drive(1, 2'b01, 0, 0, 8'h00, 0);
        e = sb.pop_front();
        checks++;
        if (cnt !== 4'd1 || done !== 1'b0 || q !== e.q) begin
            errors++;
            $display("FAIL reset_midshift: q=%h cnt=%0d done=%b want %h/1/0", q, cnt, done, e.q);
        end
    endtask

    task automatic test_shift_right();
        logic [7:0] pat;
        pat = 8'hA5;
        drive(1, 2'b11, 0, 0, 8'hA5, 0);
        e = sb.pop_front();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (sout_r !== pat[i]) begin
                errors++;
                $display("FAIL sr_sout_%0d: sout_r=%b want %b", i, sout_r, pat[i]);
            end
            drive(1, 2'b01, 0, 0, 8'h00, 0);
            e = sb.pop_front();
            checks++;
            if (q !== e.q || cnt !== e.cnt || done !== e.done || sout_l !== e.q[7]) begin
                errors++;
                $display("FAIL sr_step_%0d: q=%h cnt=%0d done=%b want %h/%0d/%b", i, q, cnt, done, e.q, e.cnt, e.done);
            end
        end
        checks++;
        if (q !== 8'h00 || cnt !== 4'd8 || done !== 1'b1) begin
            errors++;
            $display("FAIL sr_final: q=%h cnt=%0d done=%b want 00/8/1", q, cnt, done);
        end
        drive(1, 2'b01, 0, 0, 8'h00, 0);
        e = sb.pop_front();
        checks++;
        if (cnt !== 4'd8 || done !== 1'b0 || q !== e.q) begin
            errors++;
            $display("FAIL sr_saturate: q=%h cnt=%0d done=%b want %h/8/0", q, cnt, done, e.q);
        end
    endtask

    task automatic test_shift_left();
        logic [7:0] bits;
        int         pulses;
        bits = 8'b11010011;
        pulses = 0;
        drive(1, 2'b11, 0, 0, 8'h00, 0);
        e = sb.pop_front();
        for (int i = 0; i < 8; i++) begin
            drive(1, 2'b10, 0, bits[i], 8'h00, 0);
            e = sb.pop_front();
            pulses += int'(done);
            checks++;
            if (q !== e.q || cnt !== e.cnt || done !== e.done || sout_r !== e.q[0]) begin
                errors++;
                $display("FAIL sl_step_%0d: q=%h cnt=%0d done=%b want %h/%0d/%b", i, q, cnt, done, e.q, e.cnt, e.done);
            end
        end
        checks++;
        if (q !== 8'hCB || pulses != 1) begin
            errors++;
            $display("FAIL sl_final: q=%h pulses=%0d want CB/1", q, pulses);
        end
    endtask

    task automatic test_enable_hold();
        drive(1, 2'b11, 0, 0, 8'h3C, 0);
        drive(0, 2'b10, 1, 1, 8'hFF, 0);
        drive(1, 2'b00, 1, 1, 8'hFF, 0);
        drive(1, 2'b10, 0, 1, 8'hFF, 0);
        drive(0, 2'b11, 1, 1, 8'h00, 0);
        drive(1, 2'b00, 1, 1, 8'h00, 0);
        while (sb.size() > 1) begin
            e = sb.pop_front();
        end
        e = sb.pop_front();
        checks++;
        if (q !== 8'h79 || cnt !== 4'd1 || done !== 1'b0 || q !== e.q) begin
            errors++;
            $display("FAIL en_hold: q=%h cnt=%0d done=%b want 79/1/0", q, cnt, done);
        end
    endtask

    task automatic test_load_during_shift();
        int pulses;
        pulses = 0;
        drive(1, 2'b11, 0, 0, 8'hFF, 0);
        for (int i = 0; i < 5; i++) drive(1, 2'b01, 1, 0, 8'h00, 0);
        drive(1, 2'b11, 0, 0, 8'h81, 0);
        while (sb.size() > 1) begin
            e = sb.pop_front();
        end
        e = sb.pop_front();
        checks++;
        if (q !== 8'h81 || cnt !== 4'd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reload: q=%h cnt=%0d done=%b want 81/0/0", q, cnt, done);
        end
        for (int i = 0; i < 8; i++) begin
            drive(1, (i % 2 == 0) ? 2'b10 : 2'b01, 1, 0, 8'h00, 0);
            e = sb.pop_front();
            pulses += int'(done);
            checks++;
            if (q !== e.q || cnt !== e.cnt || done !== e.done) begin
                errors++;
                $display("FAIL reload_step_%0d: q=%h cnt=%0d done=%b want %h/%0d/%b", i, q, cnt, done, e.q, e.cnt, e.done);
            end
        end
        checks++;
        if (pulses != 1 || cnt !== 4'd8) begin
            errors++;
            $display("FAIL reload_pulses: pulses=%0d cnt=%0d want 1/8", pulses, cnt);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 60; i++) begin
            drive(logic'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                  1'($urandom), 1'($urandom), 8'($urandom), 0);
            e = sb.pop_front();
            checks++;
            if (q !== e.q || cnt !== e.cnt || done !== e.done ||
                sout_r !== e.q[0] || sout_l !== e.q[7]) begin
                errors++;
                $display("FAIL rand_%0d: q=%h cnt=%0d done=%b want %h/%0d/%b", i, q, cnt, done, e.q, e.cnt, e.done);
            end
        end
    endtask

`ifdef SHIFT_ROTATE_EN
    task automatic test_rotate();
        int pulses;
        pulses = 0;
        drive(1, 2'b11, 0, 0, 8'h81, 1);
        e = sb.pop_front();
        drive(1, 2'b10, 0, 0, 8'h00, 1);
        e = sb.pop_front();
        pulses += int'(done);
        checks++;
        if (q !== 8'h03 || cnt !== 4'd1) begin
            errors++;
            $display("FAIL rot_first: q=%h cnt=%0d want 03/1", q, cnt);
        end
        for (int i = 0; i < 7; i++) begin
            drive(1, 2'b10, 1, 1, 8'h00, 1);
            e = sb.pop_front();
            pulses += int'(done);
            checks++;
            if (q !== e.q || cnt !== e.cnt || done !== e.done) begin
                errors++;
                $display("FAIL rot_step_%0d: q=%h cnt=%0d done=%b want %h/%0d/%b", i, q, cnt, done, e.q, e.cnt, e.done);
            end
        end
        checks++;
        if (q !== 8'h81 || pulses != 1) begin
            errors++;
            $display("FAIL rot_final: q=%h pulses=%0d want 81/1", q, pulses);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_shift_right();
        test_shift_left();
        test_enable_hold();
        test_load_during_shift();
`ifdef SHIFT_ROTATE_EN
        test_rotate();
`endif
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
